dm_arbiter: RTL

Shares the single-ported data memory between the core load/store path (port 0) and a DMA/debug path (port 1).
- Arbitrates requests round-robin.
- Sequences each access through a small FSM.
- Steers byte lanes for SB/SH/SW, using the memory's 4-bit write enable.
- Aligns and sign/zero-extends load data for LB/LH/LW/LBU/LHU.
- Flags misaligned or unsupported accesses without touching memory.

---
 rtl/dm_pkg.sv | 34 +++
 rtl/dm_lane_align.sv | 83 ++++++++
 rtl/dm_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory arbiter:
//   - address / data widths of the data memory
//   - RISC-V funct3 encodings of the supported load/store sizes
//   - arbiter FSM state type
//   - request bundle type (one port's held request fields)
// -----------------------------------------------------------------------------
package dm_pkg;

    localparam int DM_ADDR_W = 9;   // byte-address width into data memory
    localparam int DM_DATA_W = 32;  // memory word width

    // funct3 encodings shared by loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dm_state_t;

    typedef struct packed {
        logic                 we;
        logic [DM_ADDR_W-1:0] addr;
        logic [DM_DATA_W-1:0] wdata;
        logic [2:0]           funct3;
    } dm_req_t;

endpackage : dm_pkg

// File: rtl/dm_lane_align.sv
// -----------------------------------------------------------------------------
// dm_lane_align
// Purely combinational byte-lane logic for one data-memory access.
//   we         in   1 = store, 0 = load
//   byte_off   in   addr[1:0] of the access
//   funct3     in   RISC-V funct3 of the access
//   wdata      in   right-aligned store data
//   mem_rdata  in   raw word read from memory
//   wr_mask    out  byte write enables (forced to 0 on an error)
//   wdata_lane out  store data replicated across the byte lanes
//   rdata_fmt  out  selected lane of mem_rdata, sign- or zero-extended
//   err        out  misaligned or unsupported access
// -----------------------------------------------------------------------------
module dm_lane_align
    import dm_pkg::*;
(
    input  logic                 we,
    input  logic [1:0]           byte_off,
    input  logic [2:0]           funct3,
    input  logic [DM_DATA_W-1:0] wdata,
    input  logic [DM_DATA_W-1:0] mem_rdata,
    output logic [3:0]           wr_mask,
    output logic [DM_DATA_W-1:0] wdata_lane,
    output logic [DM_DATA_W-1:0] rdata_fmt,
    output logic                 err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (byte_off)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = byte_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        wr_mask    = 4'b0000;
        wdata_lane = '0;
        rdata_fmt  = '0;
        err        = 1'b0;
        case (funct3)
            F3_B: begin
                wr_mask    = 4'b0001 << byte_off;
                wdata_lane = {4{wdata[7:0]}};
                rdata_fmt  = {{24{byte_sel[7]}}, byte_sel};
            end
            F3_H: begin
                err        = byte_off[0];
                wr_mask    = 4'b0011 << {byte_off[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                rdata_fmt  = {{16{half_sel[15]}}, half_sel};
            end
            F3_W: begin
                err        = (byte_off != 2'b00);
                wr_mask    = 4'b1111;
                wdata_lane = wdata;
                rdata_fmt  = mem_rdata;
            end
            // Unsigned variants exist only for loads
            F3_BU: begin
                err       = we;
                rdata_fmt = {24'h000000, byte_sel};
            end
            F3_HU: begin
                err       = we | byte_off[0];
                rdata_fmt = {16'h0000, half_sel};
            end
            default: begin
                err = 1'b1;
            end
        endcase
        if (err) begin
            wr_mask = 4'b0000;
        end
    end

endmodule : dm_lane_align

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Shares the single-ported data memory between port 0 (core load/store) and
// port 1 (DMA/debug). Round-robin arbitration, IDLE -> ACCESS -> RESP sequencing,
// byte-lane steering for stores and load-data formatting.
//   clk, rst_n                 clock; asynchronous active-low reset
//   pX_req/we/addr/wdata/funct3 request, held until pX_gnt
//   pX_gnt                     request accepted this cycle (combinational)
//   pX_rvalid/rdata/err        one-cycle completion with formatted data/error
//   mem_addr                   word-aligned memory address
//   mem_wdata                  lane-steered store data
//   mem_wr                     byte write enables (ACCESS only)
//   mem_rd_en                  read strobe (ACCESS only)
//   mem_rdata                  raw word from memory (memory clocked on ~clk)
// -----------------------------------------------------------------------------
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int DM_ADDRESS = DM_ADDR_W,
    parameter int DATA_W     = DM_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [DM_ADDRESS-1:0] p0_addr,
    input  logic [DATA_W-1:0]     p0_wdata,
    input  logic [2:0]            p0_funct3,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_W-1:0]     p0_rdata,
    output logic                  p0_err,

    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [DM_ADDRESS-1:0] p1_addr,
    input  logic [DATA_W-1:0]     p1_wdata,
    input  logic [2:0]            p1_funct3,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_W-1:0]     p1_rdata,
    output logic                  p1_err,

    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [3:0]            mem_wr,
    output logic                  mem_rd_en,
    input  logic [DATA_W-1:0]     mem_rdata
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    dm_state_t             state_q, state_d;
    logic                  port_q, port_d;      // port owning the current access
    logic                  last_q, last_d;      // port granted most recently
    logic                  we_q, we_d;
    logic [1:0]            off_q, off_d;
    logic [2:0]            f3_q, f3_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [DM_ADDRESS-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic    win;        // 0 = p0 wins, 1 = p1 wins
    logic    grant_any;
    dm_req_t sel_req;

    always_comb begin
        // On a tie the port that was not granted last wins
        win = (p0_req && p1_req) ? ~last_q : p1_req;
        if (win) begin
            sel_req.we     = p1_we;
            sel_req.addr   = p1_addr;
            sel_req.wdata  = p1_wdata;
            sel_req.funct3 = p1_funct3;
        end else begin
            sel_req.we     = p0_we;
            sel_req.addr   = p0_addr;
            sel_req.wdata  = p0_wdata;
            sel_req.funct3 = p0_funct3;
        end
    end

    // gnt is combinational; qualifying with rst_n keeps it low while reset is held
    assign grant_any = rst_n && (state_q == IDLE) && (p0_req || p1_req);
    assign p0_gnt    = grant_any && !win;
    assign p1_gnt    = grant_any && win;

    // ------------------------------------------------------------------
    // Lane logic: in IDLE it checks/steers the incoming request so the error
    // decision and store data are ready on the grant edge; afterwards it
    // works on the latched request to drive mem_wr and format load data.
    // ------------------------------------------------------------------
    logic                 in_idle;
    logic                 al_we;
    logic [1:0]           al_off;
    logic [2:0]           al_f3;
    logic [3:0]           al_wr;
    logic [DATA_W-1:0]    al_wdata_lane;
    logic [DATA_W-1:0]    al_rdata_fmt;
    logic                 al_err;

    assign in_idle = (state_q == IDLE);
    assign al_we   = in_idle ? sel_req.we          : we_q;
    assign al_off  = in_idle ? sel_req.addr[1:0]   : off_q;
    assign al_f3   = in_idle ? sel_req.funct3      : f3_q;

    dm_lane_align u_lane_align (
        .we         (al_we),
        .byte_off   (al_off),
        .funct3     (al_f3),
        .wdata      (sel_req.wdata),
        .mem_rdata  (mem_rdata),
        .wr_mask    (al_wr),
        .wdata_lane (al_wdata_lane),
        .rdata_fmt  (al_rdata_fmt),
        .err        (al_err)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        last_d      = last_q;
        we_d        = we_q;
        off_d       = off_q;
        f3_d        = f3_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    port_d  = win;
                    last_d  = win;
                    we_d    = sel_req.we;
                    off_d   = sel_req.addr[1:0];
                    f3_d    = sel_req.funct3;
                    err_d   = al_err;
                    rdata_d = '0;
                    if (al_err) begin
                        // Error accesses skip memory entirely
                        state_d = RESP;
                    end else begin
                        state_d    = ACCESS;
                        mem_addr_d = {sel_req.addr[DM_ADDRESS-1:2], 2'b00};
                        if (sel_req.we) begin
                            mem_wdata_d = al_wdata_lane;
                        end
                    end
                end
            end
            ACCESS: begin
                // Memory updates mem_rdata on the falling edge of this cycle
                rdata_d = we_q ? '0 : al_rdata_fmt;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            port_q      <= 1'b0;
            last_q      <= 1'b1;   // first tie goes to p0
            we_q        <= 1'b0;
            off_q       <= 2'b00;
            f3_q        <= 3'b000;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            last_q      <= last_d;
            we_q        <= we_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic in_access;
    logic in_resp;

    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wr    = (in_access && we_q) ? al_wr : 4'b0000;
    assign mem_rd_en = in_access && !we_q;

    assign p0_rvalid = in_resp && !port_q;
    assign p1_rvalid = in_resp && port_q;
    assign p0_rdata  = p0_rvalid ? rdata_q : '0;
    assign p1_rdata  = p1_rvalid ? rdata_q : '0;
    assign p0_err    = p0_rvalid && err_q;
    assign p1_err    = p1_rvalid && err_q;

endmodule : dm_arbiter
